// File: rtl/scan_addr_sequencer.sv
// Timed 4-bit scan address sequencer for a 4-to-16 decoder select (row/column strobing).
// Optional one-cycle blanking gap between addresses when SCAN_BLANK_EN is defined.
//   state | meaning
//   IDLE  | waiting for start, outputs parked at addr=0, invalid
//   SCAN  | holding addr for DWELL_CYCLES cycles
//   BLANK | one-cycle gap, addr held but invalid (SCAN_BLANK_EN only)
module scan_addr_sequencer #(
  parameter int unsigned DWELL_CYCLES = 4,
  parameter int unsigned LAST_ADDR    = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       mode,
  output logic [3:0] addr,
  output logic       addr_valid,
  output logic       busy,
  output logic       frame_done
);

  localparam int unsigned CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [3:0]       ADDR_LAST = 4'(LAST_ADDR);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_BLANK = 2'd2
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       addr_q;
  logic             addr_valid_q;
  logic             busy_q;
  logic             frame_done_q;
  logic             mode_q;

  logic             at_last;
  logic [3:0]       addr_next;

  assign at_last   = (addr_q == ADDR_LAST);
  assign addr_next = at_last ? 4'd0 : addr_q + 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      addr_q       <= 4'd0;
      addr_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      mode_q       <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // stop outranks a simultaneous start
          if (start && !stop) begin
            state_q      <= ST_SCAN;
            cnt_q        <= '0;
            addr_q       <= 4'd0;
            addr_valid_q <= 1'b1;
            busy_q       <= 1'b1;
            mode_q       <= mode;
          end
        end
        ST_SCAN: begin
          if (stop) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            addr_q       <= 4'd0;
            addr_valid_q <= 1'b0;
            busy_q       <= 1'b0;
          end else if (cnt_q != CNT_LAST) begin
            cnt_q <= cnt_q + 1'b1;
          end else begin
            cnt_q <= '0;
            if (at_last && mode_q) begin
              state_q      <= ST_IDLE;
              addr_q       <= 4'd0;
              addr_valid_q <= 1'b0;
              busy_q       <= 1'b0;
              frame_done_q <= 1'b1;
            end else begin
              frame_done_q <= at_last;
`ifdef SCAN_BLANK_EN
              state_q      <= ST_BLANK;
              addr_valid_q <= 1'b0;
`else
              addr_q       <= addr_next;
`endif
            end
          end
        end
        ST_BLANK: begin
          cnt_q <= '0;
          if (stop) begin
            state_q      <= ST_IDLE;
            addr_q       <= 4'd0;
            addr_valid_q <= 1'b0;
            busy_q       <= 1'b0;
          end else begin
            state_q      <= ST_SCAN;
            addr_q       <= addr_next;
            addr_valid_q <= 1'b1;
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          cnt_q        <= '0;
          addr_q       <= 4'd0;
          addr_valid_q <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  assign addr       = addr_q;
  assign addr_valid = addr_valid_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_scan_addr_sequencer.sv
// Bench for scan_addr_sequencer: three parameterisations checked every cycle against
// an elapsed-time arithmetic model, plus hand-computed literal expectations.
module tb_scan_addr_sequencer;

`ifdef SCAN_BLANK_EN
  localparam int BLK = 1;
`else
  localparam int BLK = 0;
`endif
  localparam int DW [3] = '{4, 1, 2};
  localparam int LA [3] = '{15, 3, 1};

  logic       clk;
  logic       rst_n;
  logic       start_s      [3];
  logic       stop_s       [3];
  logic       mode_s       [3];
  logic [3:0] addr_s       [3];
  logic       addr_valid_s [3];
  logic       busy_s       [3];
  logic       frame_done_s [3];

  int pass_cnt = 0;
  int total_cnt = 0;

  scan_addr_sequencer #(.DWELL_CYCLES(4), .LAST_ADDR(15)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]), .stop(stop_s[0]), .mode(mode_s[0]),
    .addr(addr_s[0]), .addr_valid(addr_valid_s[0]), .busy(busy_s[0]), .frame_done(frame_done_s[0]));
  scan_addr_sequencer #(.DWELL_CYCLES(1), .LAST_ADDR(3)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]), .stop(stop_s[1]), .mode(mode_s[1]),
    .addr(addr_s[1]), .addr_valid(addr_valid_s[1]), .busy(busy_s[1]), .frame_done(frame_done_s[1]));
  scan_addr_sequencer #(.DWELL_CYCLES(2), .LAST_ADDR(1)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start_s[2]), .stop(stop_s[2]), .mode(mode_s[2]),
    .addr(addr_s[2]), .addr_valid(addr_valid_s[2]), .busy(busy_s[2]), .frame_done(frame_done_s[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Model: t counts cycles since the start was accepted; outputs follow from t alone.
  int m_busy [3];
  int m_mode [3];
  int m_t    [3];
  int m_pend [3];

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        m_busy[i] = 0; m_mode[i] = 0; m_t[i] = 0; m_pend[i] = 0;
      end else begin
        m_pend[i] = 0;
        if (m_busy[i] == 0) begin
          if (start_s[i] && !stop_s[i]) begin
            m_busy[i] = 1; m_t[i] = 0; m_mode[i] = int'(mode_s[i]);
          end
        end else if (stop_s[i]) begin
          m_busy[i] = 0;
        end else begin
          m_t[i]++;
          if (m_mode[i] == 1 && m_t[i] == LA[i] * (DW[i] + BLK) + DW[i]) begin
            m_busy[i] = 0; m_pend[i] = 1;
          end
        end
      end
    end
  end

  task automatic model_out(input int i, output int ea, output int ev, output int eb, output int ed);
    int p, n;
    p = DW[i] + BLK;
    n = LA[i] + 1;
    if (m_busy[i] == 0) begin
      ea = 0; ev = 0; eb = 0; ed = m_pend[i];
    end else begin
      eb = 1;
      ea = (m_t[i] / p) % n;
      ev = ((m_t[i] % p) < DW[i]) ? 1 : 0;
`ifdef SCAN_BLANK_EN
      ed = ((m_t[i] % (n * p)) == LA[i] * p + DW[i]) ? 1 : 0;
`else
      ed = (m_t[i] > 0 && (m_t[i] % (n * p)) == 0) ? 1 : 0;
`endif
    end
  endtask

  int c_ea, c_ev, c_eb, c_ed;
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      model_out(i, c_ea, c_ev, c_eb, c_ed);
      chk($sformatf("u%0d.addr", i), int'(addr_s[i]), c_ea);
      chk($sformatf("u%0d.addr_valid", i), int'(addr_valid_s[i]), c_ev);
      chk($sformatf("u%0d.busy", i), int'(busy_s[i]), c_eb);
      chk($sformatf("u%0d.frame_done", i), int'(frame_done_s[i]), c_ed);
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  int n, dn;
  int sa [9];
  int sv [9];
  int sd [9];

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start_s[i] = 1'b0; stop_s[i] = 1'b0; mode_s[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst.addr", int'(addr_s[0]), 0);
    chk("rst.busy", int'(busy_s[0]), 0);
    chk("rst.valid", int'(addr_valid_s[0]), 0);
    repeat (10) @(negedge clk);

    // single sweep on defaults; mode flips right after start to show it was latched
    mode_s[0] = 1'b1; start_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0; mode_s[0] = 1'b0;
    chk("ss.busy_start", int'(busy_s[0]), 1);
    chk("ss.addr_start", int'(addr_s[0]), 0);
    n = 0; dn = 0;
    while (busy_s[0] && n < 200) begin
      @(negedge clk);
      n++;
      if (frame_done_s[0]) dn++;
    end
    chk("ss.length", n, (BLK == 1) ? 79 : 64);
    chk("ss.done_count", dn, 1);
    chk("ss.done_at_end", int'(frame_done_s[0]), 1);
    chk("ss.addr_after", int'(addr_s[0]), 0);
    @(negedge clk);
    chk("ss.done_one_cycle", int'(frame_done_s[0]), 0);

    // continuous wrap, DWELL=1 LAST=3
    mode_s[1] = 1'b0; start_s[1] = 1'b1;
    @(negedge clk);
    start_s[1] = 1'b0;
    for (int k = 0; k < 9; k++) begin
      sa[k] = int'(addr_s[1]); sd[k] = int'(frame_done_s[1]);
      @(negedge clk);
    end
`ifdef SCAN_BLANK_EN
    chk("wrap.a6", sa[6], 3);
    chk("wrap.fd7", sd[7], 1);
    chk("wrap.fd5", sd[5], 0);
    chk("wrap.a8", sa[8], 0);
`else
    chk("wrap.a3", sa[3], 3);
    chk("wrap.a4", sa[4], 0);
    chk("wrap.fd3", sd[3], 0);
    chk("wrap.fd4", sd[4], 1);
    chk("wrap.fd8", sd[8], 1);
`endif
    // stop exactly on the cycle that would end the sweep: no pulse
    n = 0;
    while (addr_s[1] != 4'd3 && n < 50) begin @(negedge clk); n++; end
    chk("wrap.reach3", (n < 50) ? 1 : 0, 1);
    stop_s[1] = 1'b1;
    @(negedge clk);
    stop_s[1] = 1'b0;
    chk("wrap.stop_busy", int'(busy_s[1]), 0);
    chk("wrap.stop_done", int'(frame_done_s[1]), 0);

    // mid-sweep stop at addr 7, then restart
    mode_s[0] = 1'b0; start_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    n = 0;
    while (addr_s[0] != 4'd7 && n < 200) begin @(negedge clk); n++; end
    chk("stop.reach7", (n < 200) ? 1 : 0, 1);
    stop_s[0] = 1'b1;
    @(negedge clk);
    stop_s[0] = 1'b0;
    chk("stop.busy", int'(busy_s[0]), 0);
    chk("stop.valid", int'(addr_valid_s[0]), 0);
    chk("stop.addr", int'(addr_s[0]), 0);
    chk("stop.done", int'(frame_done_s[0]), 0);
    start_s[0] = 1'b1; stop_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0; stop_s[0] = 1'b0;
    chk("startstop.busy", int'(busy_s[0]), 0);
    start_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    chk("restart.busy", int'(busy_s[0]), 1);
    chk("restart.addr", int'(addr_s[0]), 0);
    repeat (5) @(negedge clk);
    chk("restart.addr5", int'(addr_s[0]), 1);
    start_s[0] = 1'b1; mode_s[0] = 1'b1;
    repeat (3) @(negedge clk);
    start_s[0] = 1'b0; mode_s[0] = 1'b0;
    repeat (80) @(negedge clk);
    chk("busy_start_ignored", int'(busy_s[0]), 1);

    // blanking instance DWELL=2 LAST=1, continuous
    mode_s[2] = 1'b0; start_s[2] = 1'b1;
    @(negedge clk);
    start_s[2] = 1'b0;
    for (int k = 0; k < 7; k++) begin
      sa[k] = int'(addr_s[2]); sv[k] = int'(addr_valid_s[2]); sd[k] = int'(frame_done_s[2]);
      @(negedge clk);
    end
`ifdef SCAN_BLANK_EN
    chk("blank.v", sv[0]*32 + sv[1]*16 + sv[2]*8 + sv[3]*4 + sv[4]*2 + sv[5], 6'b110110);
    chk("blank.a", sa[0]*32 + sa[1]*16 + sa[2]*8 + sa[3]*4 + sa[4]*2 + sa[5], 6'b000111);
    chk("blank.fd2", sd[2], 0);
    chk("blank.fd5", sd[5], 1);
`else
    chk("blank.v", sv[0]*32 + sv[1]*16 + sv[2]*8 + sv[3]*4 + sv[4]*2 + sv[5], 6'b111111);
    chk("blank.a", sa[0]*32 + sa[1]*16 + sa[2]*8 + sa[3]*4 + sa[4]*2 + sa[5], 6'b001100);
    chk("blank.fd4", sd[4], 1);
    chk("blank.fd5", sd[5], 0);
`endif
    stop_s[2] = 1'b1;
    @(negedge clk);
    stop_s[2] = 1'b0;
    mode_s[2] = 1'b1; start_s[2] = 1'b1;
    @(negedge clk);
    start_s[2] = 1'b0;
    n = 0;
    while (busy_s[2] && n < 50) begin @(negedge clk); n++; end
    chk("blank.single_len", n, (BLK == 1) ? 5 : 4);

    // asynchronous reset while u0 is mid-sweep
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.busy", int'(busy_s[0]), 0);
    chk("arst.addr", int'(addr_s[0]), 0);
    chk("arst.valid", int'(addr_valid_s[0]), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
